// File: rtl/conv_window_gen.sv
// Sliding KxK window generator over a raster pixel stream.
// Line buffer holds the last K rows; windows leave through a valid/ready register.
module conv_window_gen #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 3,
  parameter int STRIDE    = 1,
  parameter int DATA_BITS = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_BITS-1:0]       in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [K*K*DATA_BITS-1:0]   win_data,
  output logic                       out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int KW = $clog2(K);
  localparam int SW = KW + 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int WW = K * K * DATA_BITS;
  localparam int LAST_R = K - 1 + ((IMG_H - K) / STRIDE) * STRIDE;
  localparam int LAST_C = K - 1 + ((IMG_W - K) / STRIDE) * STRIDE;

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic [KW-1:0]        r_slot;
  logic [PW-1:0]        r_cph;
  logic [PW-1:0]        r_rph;
  logic                 r_valid;
  logic                 r_last;
  logic [WW-1:0]        r_win;
  logic [DATA_BITS-1:0] r_buf [K][IMG_W];

  logic          w_acc;
  logic          w_fire;
  logic          w_last_pos;
  logic          w_col_end;
  logic          w_row_end;
  logic [SW-1:0] w_slot_x;
  logic [WW-1:0] w_win;

  assign in_ready   = !r_valid || out_ready;
  assign out_valid  = r_valid;
  assign out_last   = r_last;
  assign win_data   = r_win;

  assign w_acc      = in_valid && in_ready && !clear;
  assign w_col_end  = r_col == CW'(IMG_W - 1);
  assign w_row_end  = r_row == RW'(IMG_H - 1);
  assign w_fire     = w_acc
                   && (r_col >= CW'(K - 1))
                   && (r_row >= RW'(K - 1))
                   && (r_cph == '0)
                   && (r_rph == '0);
  assign w_last_pos = (r_col == CW'(LAST_C))
                   && (r_row == RW'(LAST_R));
  assign w_slot_x   = {1'b0, r_slot};

  // r_cph/r_rph hold (pos-K+1) mod STRIDE once pos >= K-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_slot <= '0;
      r_cph  <= '0;
      r_rph  <= '0;
    end else if (clear) begin
      r_col  <= '0;
      r_row  <= '0;
      r_slot <= '0;
      r_cph  <= '0;
      r_rph  <= '0;
    end else if (w_acc) begin
      if (w_col_end) begin
        r_col <= '0;
        r_cph <= '0;
        if (w_row_end) begin
          r_row  <= '0;
          r_slot <= '0;
          r_rph  <= '0;
        end else begin
          r_row  <= r_row + 1'b1;
          r_slot <= (r_slot == KW'(K - 1)) ? '0 : r_slot + 1'b1;
          if (r_row >= RW'(K - 1))
            r_rph <= (r_rph == PW'(STRIDE - 1)) ? '0 : r_rph + 1'b1;
          else
            r_rph <= '0;
        end
      end else begin
        r_col <= r_col + 1'b1;
        if (r_col >= CW'(K - 1))
          r_cph <= (r_cph == PW'(STRIDE - 1)) ? '0 : r_cph + 1'b1;
        else
          r_cph <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_win   <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_last  <= w_last_pos;
      r_win   <= w_win;
    end else if (out_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc)
      r_buf[r_slot][r_col] <= in_data;
  end

  // Row slot for window row i is (slot + i + 1) mod K
  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      if (gi == K - 1 && gj == K - 1) begin : g_new
        assign w_win[(gi*K+gj)*DATA_BITS +: DATA_BITS] = in_data;
      end else begin : g_buf
        logic [SW-1:0] w_s;
        logic [KW-1:0] w_sl;
        logic [CW-1:0] w_c;
        assign w_s  = w_slot_x + SW'(gi + 1);
        assign w_sl = (w_s >= SW'(K)) ? KW'(w_s - SW'(K))
                                      : KW'(w_s);
        assign w_c  = r_col - CW'(K - 1 - gj);
        assign w_win[(gi*K+gj)*DATA_BITS +: DATA_BITS] =
          r_buf[w_sl][w_c];
      end
    end
  end

endmodule
